// File: rtl/four_bit_serializer_pkg.sv
// four_bit_serializer_pkg: shared state encoding and counter-width helper for the serializer.
package four_bit_serializer_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/four_bit_serializer_shift_bit_counter.sv
// shift_bit_counter: mod-WIDTH bit-position counter with synchronous clear and last-bit flag.
import four_bit_serializer_pkg::*;
module shift_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_last
);
  assign at_last = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= at_last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/four_bit_serializer.sv
// four_bit_serializer: accepts a parallel word per handshake and shifts it out one bit per clock.
import four_bit_serializer_pkg::*;
module four_bit_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last
);
  localparam int CNT_W   = clog2(WIDTH);
  localparam int OUT_IDX = MSB_FIRST != 0 ? WIDTH - 1 : 0;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             at_last, adv, accept;
  assign adv      = state == S_SHIFT && ser_ready;
  assign in_ready = state == S_IDLE || (adv && at_last);
  assign accept   = in_valid && in_ready;
  shift_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(accept || (adv && at_last)), .en(adv),
    .cnt(cnt), .at_last(at_last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= S_SHIFT;
      shreg <= in;
    end else if (adv) begin
      state <= at_last ? S_IDLE : S_SHIFT;
      shreg <= MSB_FIRST != 0 ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  assign ser_valid = state == S_SHIFT;
  assign ser_out   = ser_valid && shreg[OUT_IDX];
  assign ser_first = ser_valid && cnt == '0;
  assign ser_last  = ser_valid && at_last;
endmodule

// File: tb/tb_four_bit_serializer.sv
// tb_four_bit_serializer: directed checks of framing, back-to-back, stall, busy-ignore, abort and LSB-first order.
module tb_four_bit_serializer;
  logic clk = 0, rst = 1, sr = 1, sel = 0;
  logic [3:0] in_m = 0, in_l = 0;
  logic valid_m = 0, valid_l = 0;
  logic rdy_m, out_m, sv_m, sf_m, sl_m;
  logic rdy_l, out_l, sv_l, sf_l, sl_l;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  four_bit_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in(in_m), .in_valid(valid_m), .in_ready(rdy_m), .ser_ready(sr),
    .ser_out(out_m), .ser_valid(sv_m), .ser_first(sf_m), .ser_last(sl_m)
  );
  four_bit_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in(in_l), .in_valid(valid_l), .in_ready(rdy_l), .ser_ready(sr),
    .ser_out(out_l), .ser_valid(sv_l), .ser_first(sf_l), .ser_last(sl_l)
  );
  wire o_rdy   = sel ? rdy_l : rdy_m;
  wire o_out   = sel ? out_l : out_m;
  wire o_valid = sel ? sv_l : sv_m;
  wire o_first = sel ? sf_l : sf_m;
  wire o_last  = sel ? sl_l : sl_m;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_out"}, 32'(o_out), 0);
    chk({tag, "_first"}, 32'(o_first), 0);
    chk({tag, "_last"}, 32'(o_last), 0);
    chk({tag, "_rdy"}, 32'(o_rdy), 1);
  endtask
  // b lists the bits in transmission order, leftmost first; assumes ser_ready=1
  task automatic frame(input string tag, input logic [3:0] b);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(o_valid), 1);
      chk($sformatf("%s_out%0d", tag, i), 32'(o_out), 32'(b[3-i]));
      chk($sformatf("%s_first%0d", tag, i), 32'(o_first), 32'(i == 0));
      chk($sformatf("%s_last%0d", tag, i), 32'(o_last), 32'(i == 3));
      chk($sformatf("%s_rdy%0d", tag, i), 32'(o_rdy), 32'(i == 3));
      step();
    end
  endtask
  initial begin
    #3 rst = 0;
    #1 chk_idle("rst0");
    #18 rst = 1;
    step();
    chk_idle("idle");
    // single word 1011
    in_m = 4'b1011; valid_m = 1;
    step();
    valid_m = 0;
    frame("single", 4'b1011);
    chk("single_end", 32'(o_valid), 0);
    // back-to-back A then 5
    in_m = 4'hA; valid_m = 1;
    step();
    in_m = 4'h5;
    frame("b2b_a", 4'hA);
    valid_m = 0;
    frame("b2b_5", 4'h5);
    chk("b2b_end", 32'(o_valid), 0);
    // stall on bit 2 of C
    in_m = 4'hC; valid_m = 1;
    step();
    valid_m = 0;
    chk("st_b0", 32'(o_out), 1);
    step();
    chk("st_b1", 32'(o_out), 1);
    step();
    sr = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_hold_out%0d", i), 32'(o_out), 0);
      chk($sformatf("st_hold_valid%0d", i), 32'(o_valid), 1);
      chk($sformatf("st_hold_first%0d", i), 32'(o_first), 0);
      chk($sformatf("st_hold_last%0d", i), 32'(o_last), 0);
      step();
    end
    sr = 1;
    chk("st_b2", 32'(o_out), 0);
    chk("st_b2_last", 32'(o_last), 0);
    step();
    chk("st_b3", 32'(o_out), 0);
    chk("st_b3_last", 32'(o_last), 1);
    step();
    chk("st_end", 32'(o_valid), 0);
    // ignore F while busy with 6
    in_m = 4'h6; valid_m = 1;
    step();
    valid_m = 0;
    chk("busy_b0", 32'(o_out), 0);
    chk("busy_b0_first", 32'(o_first), 1);
    step();
    in_m = 4'hF; valid_m = 1;
    chk("busy_rdy1", 32'(o_rdy), 0);
    chk("busy_b1", 32'(o_out), 1);
    step();
    chk("busy_rdy2", 32'(o_rdy), 0);
    chk("busy_b2", 32'(o_out), 1);
    step();
    chk("busy_b3", 32'(o_out), 0);
    chk("busy_b3_last", 32'(o_last), 1);
    chk("busy_rdy3", 32'(o_rdy), 1);
    step();
    valid_m = 0;
    frame("busy_f", 4'hF);
    chk("busy_end", 32'(o_valid), 0);
    // abort at bit 2 of 9
    in_m = 4'h9; valid_m = 1;
    step();
    valid_m = 0;
    step();
    step();
    chk("ab_pre_valid", 32'(o_valid), 1);
    chk("ab_pre_out", 32'(o_out), 0);
    #2 rst = 0;
    #1 chk_idle("abort");
    step();
    chk_idle("abort_hold");
    #2 rst = 1;
    step();
    chk_idle("abort_rel");
    // LSB-first 0001 -> 1,0,0,0
    sel = 1;
    chk_idle("lsb_idle");
    in_l = 4'b0001; valid_l = 1;
    step();
    valid_l = 0;
    frame("lsb", 4'b1000);
    chk("lsb_end", 32'(o_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
